// File: rtl/jk_mod_counter_pkg.sv
// Shared control-decode types for the JK-cell mod-N counter.
// The control priority (clr > load > en > hold) is fixed here so every user decodes it the same way.
package jk_mod_counter_pkg;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_COUNT = 2'd1,
    OP_LOAD  = 2'd2,
    OP_CLR   = 2'd3
  } op_e;

  function automatic op_e decode_op(input logic clr, input logic load, input logic en);
    if (clr)       return OP_CLR;
    else if (load) return OP_LOAD;
    else if (en)   return OP_COUNT;
    else           return OP_HOLD;
  endfunction

endpackage

// File: rtl/jk_mod_counter_jk_ff.sv
// Single JK flip-flop cell with asynchronous active-high reset.
// J and K are gated into set/reset against the current state, so set and reset can never both be active.
module jk_ff (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_q;
  logic q_d;
  logic s_w;
  logic r_w;

  assign s_w = j & ~q_q;
  assign r_w = k & q_q;

  always_comb begin
    q_d = q_q;
    if (s_w)      q_d = 1'b1;
    else if (r_w) q_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= 1'b0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/jk_mod_counter.sv
// Mod-N up/down counter built from one JK cell per state bit, driven in toggle mode by a shared decoder.
// Provides a combinational terminal count, a registered wrap pulse and a sticky out-of-range-load flag.
module jk_mod_counter
  import jk_mod_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             en,
  input  logic             up,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             err
);

  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("jk_mod_counter: MODULUS must be in 2..2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MAXV    = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  op_e              op;
  logic [WIDTH-1:0] q_cells;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] toggle;
  logic             load_ok;
  logic             at_end;
  logic             tc_w;
  logic             wrap_q;
  logic             wrap_d;
  logic             err_q;
  logic             err_d;

  assign op      = decode_op(clr, load, en);
  // Widened compare so MODULUS == 2**WIDTH accepts every load value.
  assign load_ok = {1'b0, d} < MOD_EXT;
  assign at_end  = up ? (q_cells == MAXV) : (q_cells == '0);
  assign tc_w    = (op == OP_COUNT) & at_end;

  always_comb begin
    nxt = q_cells;
    unique case (op)
      OP_CLR:   nxt = '0;
      OP_LOAD:  nxt = load_ok ? d : '0;
      OP_COUNT: begin
        if (up) nxt = (q_cells == MAXV) ? '0 : q_cells + WIDTH'(1);
        else    nxt = (q_cells == '0) ? MAXV : q_cells - WIDTH'(1);
      end
      OP_HOLD:  nxt = q_cells;
    endcase
  end

  // Toggle exactly the bits that differ from the decoded next state.
  assign toggle = q_cells ^ nxt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_ff u_ff (
      .clk (clk),
      .rst (rst),
      .j   (toggle[i]),
      .k   (toggle[i]),
      .q   (q_cells[i])
    );
  end

  assign wrap_d = tc_w;
  assign err_d  = err_q | ((op == OP_LOAD) & ~load_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign q    = q_cells;
  assign tc   = tc_w;
  assign wrap = wrap_q;
  assign err  = err_q;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Self-checking bench for jk_mod_counter: directed vector table, hand sequences and
// randomized traffic against an arithmetic reference model, on MODULUS=10 and MODULUS=16 instances.
module tb_jk_mod_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic       load;
  logic       en;
  logic       up;
  logic [3:0] d;

  logic [3:0] q10;
  logic       tc10;
  logic       wrap10;
  logic       err10;
  logic [3:0] q16;
  logic       tc16;
  logic       wrap16;
  logic       err16;

  int tests_run    = 0;
  int tests_failed = 0;

  int model_q[2];
  int model_err[2];
  int model_wrap[2];
  int model_mod[2] = '{10, 16};

  typedef struct {
    bit rst;
    bit clr;
    bit load;
    bit en;
    bit up;
    int d;
    int tc;
    int q;
    int wrap;
    int err;
  } vec_t;

  vec_t vecs[23];

  always #5 clk = ~clk;

  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .load (load),
    .en   (en),
    .up   (up),
    .d    (d),
    .q    (q10),
    .tc   (tc10),
    .wrap (wrap10),
    .err  (err10)
  );

  jk_mod_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .load (load),
    .en   (en),
    .up   (up),
    .d    (d),
    .q    (q16),
    .tc   (tc16),
    .wrap (wrap16),
    .err  (err16)
  );

  task automatic check_output(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // A JK cell must never see set and reset together.
  logic sr_conflict;
  assign sr_conflict =
      (dut.g_bit[0].u_ff.s_w & dut.g_bit[0].u_ff.r_w) |
      (dut.g_bit[1].u_ff.s_w & dut.g_bit[1].u_ff.r_w) |
      (dut.g_bit[2].u_ff.s_w & dut.g_bit[2].u_ff.r_w) |
      (dut.g_bit[3].u_ff.s_w & dut.g_bit[3].u_ff.r_w) |
      (dut16.g_bit[0].u_ff.s_w & dut16.g_bit[0].u_ff.r_w) |
      (dut16.g_bit[1].u_ff.s_w & dut16.g_bit[1].u_ff.r_w) |
      (dut16.g_bit[2].u_ff.s_w & dut16.g_bit[2].u_ff.r_w) |
      (dut16.g_bit[3].u_ff.s_w & dut16.g_bit[3].u_ff.r_w);

  always @(negedge clk) begin
    if (rst === 1'b0) check_output("jk_sr_exclusive", int'(sr_conflict), 0);
  end

  function automatic int model_tc(input int idx);
    int m;
    m = model_mod[idx];
    if (!en || clr || load) return 0;
    if (up) return (model_q[idx] == m - 1) ? 1 : 0;
    return (model_q[idx] == 0) ? 1 : 0;
  endfunction

  // Drive inputs just after the falling edge; async reset hits the model immediately.
  task automatic apply_stimulus(input bit r, input bit c, input bit l, input bit e,
                                input bit u, input int dv);
    @(negedge clk);
    rst  = r;
    clr  = c;
    load = l;
    en   = e;
    up   = u;
    d    = 4'(dv);
    if (r) begin
      for (int i = 0; i < 2; i++) begin
        model_q[i]    = 0;
        model_err[i]  = 0;
        model_wrap[i] = 0;
      end
    end
    #1;
  endtask

  task automatic clock_edge();
    int tcs[2];
    int m;
    for (int i = 0; i < 2; i++) tcs[i] = model_tc(i);
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      m = model_mod[i];
      if (rst) begin
        model_q[i]    = 0;
        model_err[i]  = 0;
        model_wrap[i] = 0;
      end else begin
        model_wrap[i] = tcs[i];
        if (clr) begin
          model_q[i] = 0;
        end else if (load) begin
          if (int'(d) < m) begin
            model_q[i] = int'(d);
          end else begin
            model_q[i]   = 0;
            model_err[i] = 1;
          end
        end else if (en) begin
          model_q[i] = up ? (model_q[i] + 1) % m : (model_q[i] + m - 1) % m;
        end
      end
    end
    #1;
  endtask

  task automatic check_models_tc();
    check_output("model_tc10", int'(tc10), model_tc(0));
    check_output("model_tc16", int'(tc16), model_tc(1));
  endtask

  task automatic check_models_state();
    check_output("model_q10",    int'(q10),    model_q[0]);
    check_output("model_wrap10", int'(wrap10), model_wrap[0]);
    check_output("model_err10",  int'(err10),  model_err[0]);
    check_output("model_q16",    int'(q16),    model_q[1]);
    check_output("model_wrap16", int'(wrap16), model_wrap[1]);
    check_output("model_err16",  int'(err16),  model_err[1]);
  endtask

  initial begin
    // rst clr load en up d | tc q wrap err   (tc before the edge, the rest after it), MODULUS=10
    vecs = '{
      '{0,0,0,0,1, 0, 0,0,0,0},
      '{0,0,1,0,1, 7, 0,7,0,0},
      '{0,0,0,1,1, 0, 0,8,0,0},
      '{0,0,0,1,1, 0, 0,9,0,0},
      '{0,0,0,1,1, 0, 1,0,1,0},
      '{0,0,0,1,1, 0, 0,1,0,0},
      '{0,0,0,0,1, 0, 0,1,0,0},
      '{0,0,1,0,1, 0, 0,0,0,0},
      '{0,0,0,1,0, 0, 1,9,1,0},
      '{0,0,0,1,0, 0, 0,8,0,0},
      '{0,0,1,1,0,12, 0,0,0,1},
      '{0,1,0,0,1, 0, 0,0,0,1},
      '{0,1,1,1,1, 3, 0,0,0,1},
      '{0,0,1,1,1, 3, 0,3,0,1},
      '{0,0,0,1,0, 0, 0,2,0,1},
      '{0,0,1,0,1, 9, 0,9,0,1},
      '{0,1,0,1,1, 0, 0,0,0,1},
      '{0,0,1,0,1,10, 0,0,0,1},
      '{1,0,0,1,1, 0, 0,0,0,0},
      '{0,0,0,1,1, 0, 0,1,0,0},
      '{0,0,1,1,1, 9, 0,9,0,0},
      '{0,0,0,1,1, 0, 1,0,1,0},
      '{0,0,0,0,1, 0, 0,0,0,0}
    };

    for (int i = 0; i < 2; i++) begin
      model_q[i]    = 0;
      model_err[i]  = 0;
      model_wrap[i] = 0;
    end

    apply_stimulus(1, 0, 0, 0, 1, 0);
    check_output("reset_q",    int'(q10),    0);
    check_output("reset_wrap", int'(wrap10), 0);
    check_output("reset_err",  int'(err10),  0);
    clock_edge();

    for (int i = 0; i < 23; i++) begin
      apply_stimulus(vecs[i].rst, vecs[i].clr, vecs[i].load, vecs[i].en, vecs[i].up, vecs[i].d);
      check_output($sformatf("vec%0d_tc", i), int'(tc10), vecs[i].tc);
      clock_edge();
      check_output($sformatf("vec%0d_q", i),    int'(q10),    vecs[i].q);
      check_output($sformatf("vec%0d_wrap", i), int'(wrap10), vecs[i].wrap);
      check_output($sformatf("vec%0d_err", i),  int'(err10),  vecs[i].err);
    end

    // Asynchronous reset in the middle of a cycle, with err set and q at 5.
    apply_stimulus(0, 0, 1, 0, 1, 12);
    clock_edge();
    apply_stimulus(0, 0, 1, 0, 1, 5);
    clock_edge();
    check_output("pre_rst_q",   int'(q10),   5);
    check_output("pre_rst_err", int'(err10), 1);
    apply_stimulus(1, 0, 0, 1, 1, 0);
    check_output("async_rst_q",    int'(q10),    0);
    check_output("async_rst_wrap", int'(wrap10), 0);
    check_output("async_rst_err",  int'(err10),  0);
    clock_edge();
    check_output("rst_hold_q", int'(q10), 0);
    apply_stimulus(0, 0, 0, 0, 1, 0);
    clock_edge();
    check_output("post_rst_idle_q", int'(q10), 0);

    // Full binary modulus: 15 -> 0 wraps with a pulse.
    apply_stimulus(0, 0, 1, 0, 1, 15);
    clock_edge();
    check_output("m16_load_q",   int'(q16),   15);
    check_output("m16_load_err", int'(err16), 0);
    apply_stimulus(0, 0, 0, 1, 1, 0);
    check_output("m16_tc", int'(tc16), 1);
    clock_edge();
    check_output("m16_wrap_q",    int'(q16),    0);
    check_output("m16_wrap_wrap", int'(wrap16), 1);
    apply_stimulus(0, 0, 0, 0, 1, 0);
    clock_edge();
    check_output("m16_wrap_clear", int'(wrap16), 0);

    for (int n = 0; n < 10000; n++) begin
      apply_stimulus(($urandom_range(0, 199) == 0),
                     ($urandom_range(0, 15) == 0),
                     ($urandom_range(0, 7) == 0),
                     ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 1) == 1),
                     int'($urandom_range(0, 15)));
      check_models_tc();
      clock_edge();
      check_models_state();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
